// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the data-RAM arbiter between the core
// load/store port and the JPEG block-transfer DMA.
package dram_arb_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    DMA_LOCK = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_DMA  = 1'b1
  } owner_t;

  // Beat counter must hold values 0..maxburst inclusive.
  function automatic int beat_cnt_w(input int maxburst);
    return $clog2(maxburst + 1);
  endfunction

endpackage

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the core
// (requester 0) and the JPEG DMA (requester 1). Grants are combinational in
// the request cycle; the DMA may lock the RAM for bounded bursts; read data
// returns one cycle later and is steered by registered return flags.
module dram_arbiter
  import dram_arb_pkg::*;
#(
  parameter int DATAW    = 32,
  parameter int ADDRW    = 10,
  parameter int RAMDEPTH = 1024,
  parameter int MAXBURST = 16
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             core_req,
  input  logic             core_we,
  input  logic [ADDRW-1:0] core_addr,
  input  logic [DATAW-1:0] core_wdata,
  output logic             core_stall,
  output logic             core_gnt,
  output logic             core_rvalid,
  input  logic             dma_req,
  input  logic             dma_lock,
  input  logic             dma_we,
  input  logic [ADDRW-1:0] dma_addr,
  input  logic [DATAW-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [DATAW-1:0] rdata,
  output logic             addr_err,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ADDRW-1:0] ram_addr,
  output logic [DATAW-1:0] ram_wdata,
  input  logic [DATAW-1:0] ram_rdata
);

  localparam int             CNTW       = beat_cnt_w(MAXBURST);
  localparam logic [CNTW-1:0] BURST_LAST = CNTW'(MAXBURST);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);

  // Addresses at or above RAMDEPTH have no backing storage.
  function automatic logic in_range(input logic [ADDRW-1:0] a);
    return 64'(a) < 64'(RAMDEPTH);
  endfunction

  arb_state_t       state, state_nxt;
  owner_t           last_owner, owner_nxt;
  logic [CNTW-1:0]  cnt, cnt_nxt;

  logic             pick_core;
  logic             pick_dma;
  logic             acc_gnt;
  logic             acc_ok;
  logic             sel_we;
  logic [ADDRW-1:0] sel_addr;
  logic [DATAW-1:0] sel_wdata;

  logic             rv_core_p1;
  logic             rv_dma_p1;
  logic             rv_zero_p1;
  logic             vld_p1;

  // Pick the winner: the locked DMA owns the RAM, otherwise round-robin on ties.
  always_comb begin
    pick_core = 1'b0;
    pick_dma  = 1'b0;
    if (state == DMA_LOCK) begin
      pick_dma = dma_req;
    end else if (core_req && dma_req) begin
      pick_core = (last_owner == OWN_DMA);
      pick_dma  = (last_owner == OWN_CORE);
    end else begin
      pick_core = core_req;
      pick_dma  = dma_req;
    end
  end

  // ---- stage 0: winner mux onto the RAM port (request cycle) ----
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (pick_core) begin
      sel_we    = core_we;
      sel_addr  = core_addr;
      sel_wdata = core_wdata;
    end else if (pick_dma) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  assign acc_gnt    = pick_core | pick_dma;
  assign acc_ok     = in_range(sel_addr);
  assign core_gnt   = pick_core;
  assign dma_gnt    = pick_dma;
  assign core_stall = core_req & ~pick_core;
  assign ram_en     = acc_gnt & acc_ok;
  assign ram_we     = acc_gnt & acc_ok & sel_we;
  assign ram_addr   = sel_addr;
  assign ram_wdata  = sel_wdata;

  // Next arbitration state, owner and burst beat count.
  always_comb begin
    state_nxt = state;
    owner_nxt = last_owner;
    cnt_nxt   = cnt;
    if (pick_core) owner_nxt = OWN_CORE;
    if (pick_dma)  owner_nxt = OWN_DMA;
    case (state)
      ARB: begin
        if (pick_dma && dma_lock) begin
          state_nxt = DMA_LOCK;
          cnt_nxt   = CNT_ONE;
        end
      end
      DMA_LOCK: begin
        if (!dma_req) begin
          state_nxt = ARB;
          cnt_nxt   = '0;
        end else if (!dma_lock || (cnt + CNT_ONE) == BURST_LAST) begin
          // This beat is still issued; the core gets the next cycle.
          state_nxt = ARB;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ARB;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Arbitration control registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state      <= ARB;
      last_owner <= OWN_DMA;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  // ---- stage 1: read-return flags, sticky address error ----
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      rv_core_p1 <= 1'b0;
      rv_dma_p1  <= 1'b0;
      rv_zero_p1 <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      rv_core_p1 <= pick_core & ~core_we;
      rv_dma_p1  <= pick_dma & ~dma_we;
      rv_zero_p1 <= acc_gnt & ~acc_ok;
      addr_err   <= addr_err | (acc_gnt & ~acc_ok);
    end
  end

  assign vld_p1      = rv_core_p1 | rv_dma_p1;
  assign core_rvalid = rv_core_p1;
  assign dma_rvalid  = rv_dma_p1;
  assign rdata       = (vld_p1 && !rv_zero_p1) ? ram_rdata : '0;

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus a randomized
// run, all checked against a behavioural model of the arbitration rules and
// a reference copy of the RAM contents.
module tb_dram_arbiter;

  localparam int DATAW    = 32;
  localparam int ADDRW    = 10;
  localparam int RAMDEPTH = 768;
  localparam int MAXBURST = 16;
  localparam int NWORDS   = 1 << ADDRW;

  logic             clock = 1'b0;
  logic             nreset = 1'b0;
  logic             core_req = 1'b0, core_we = 1'b0;
  logic [ADDRW-1:0] core_addr = '0;
  logic [DATAW-1:0] core_wdata = '0;
  logic             dma_req = 1'b0, dma_lock = 1'b0, dma_we = 1'b0;
  logic [ADDRW-1:0] dma_addr = '0;
  logic [DATAW-1:0] dma_wdata = '0;
  logic             core_stall, core_gnt, core_rvalid;
  logic             dma_gnt, dma_rvalid, addr_err;
  logic [DATAW-1:0] rdata;
  logic             ram_en, ram_we;
  logic [ADDRW-1:0] ram_addr;
  logic [DATAW-1:0] ram_wdata;
  logic [DATAW-1:0] ram_rdata;

  always #5 clock = ~clock;

  dram_arbiter #(
    .DATAW(DATAW), .ADDRW(ADDRW), .RAMDEPTH(RAMDEPTH), .MAXBURST(MAXBURST)
  ) dut (
    .clock(clock), .nreset(nreset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_stall(core_stall), .core_gnt(core_gnt),
    .core_rvalid(core_rvalid),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid),
    .rdata(rdata), .addr_err(addr_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM attached to the arbiter.
  function automatic logic [DATAW-1:0] init_word(input int i);
    if (i == 5) return 32'h0000_1234;
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  logic [DATAW-1:0] mem [NWORDS];
  logic [DATAW-1:0] ram_q;
  bit               preloaded = 1'b0;

  always @(posedge clock) begin
    if (!preloaded) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= init_word(i);
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_q <= mem[ram_addr];
    end
  end
  assign ram_rdata = ram_q;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- behavioural reference model ----------------
  logic [DATAW-1:0] ref_mem [NWORDS];
  bit               m_turn_core;   // core wins the next tie
  int               m_lock;        // beats issued in the current locked burst, 0 = none
  logic             m_rv_core, m_rv_dma, m_err;
  logic [DATAW-1:0] m_rd;

  logic             e_cg, e_dg, e_stall, e_en, e_we, e_isw, e_oor;
  logic [ADDRW-1:0] e_addr;
  logic [DATAW-1:0] e_wdata;

  task automatic model_reset();
    m_turn_core = 1'b1;
    m_lock      = 0;
    m_rv_core   = 1'b0;
    m_rv_dma    = 1'b0;
    m_err       = 1'b0;
    m_rd        = '0;
  endtask

  task automatic model_eval();
    if (m_lock > 0) begin
      e_cg = 1'b0;
      e_dg = dma_req;
    end else if (core_req && dma_req) begin
      e_cg = m_turn_core;
      e_dg = !m_turn_core;
    end else begin
      e_cg = core_req;
      e_dg = dma_req;
    end
    e_stall = core_req && !e_cg;
    e_addr  = e_cg ? core_addr  : (e_dg ? dma_addr  : '0);
    e_wdata = e_cg ? core_wdata : (e_dg ? dma_wdata : '0);
    e_isw   = e_cg ? core_we    : (e_dg ? dma_we    : 1'b0);
    e_oor   = (e_cg || e_dg) && (int'(e_addr) >= RAMDEPTH);
    e_en    = (e_cg || e_dg) && !e_oor;
    e_we    = e_en && e_isw;
  endtask

  task automatic model_commit();
    m_rv_core = e_cg && !e_isw;
    m_rv_dma  = e_dg && !e_isw;
    if ((e_cg || e_dg) && !e_isw) m_rd = e_oor ? '0 : ref_mem[e_addr];
    if (e_we) ref_mem[e_addr] = e_wdata;
    if (e_oor) m_err = 1'b1;
    if (m_lock > 0) begin
      if (!dma_req) m_lock = 0;
      else if (!dma_lock || m_lock + 1 == MAXBURST) m_lock = 0;
      else m_lock = m_lock + 1;
    end else if (e_dg && dma_lock) begin
      m_lock = 1;
    end
    if (e_cg) m_turn_core = 1'b0;
    if (e_dg) m_turn_core = 1'b1;
  endtask

  // Advance one clock: model follows the same edge as the DUT.
  task automatic tick();
    model_eval();
    @(posedge clock);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    dma_req = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nreset = 1'b0;
    model_reset();
    #14;
    nreset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    @(posedge clock);
    #1;
    preloaded = 1'b1;
    model_reset();
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt, ram_en, ram_we, core_stall, core_rvalid, dma_rvalid, addr_err} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000000",
               {core_gnt, dma_gnt, ram_en, ram_we, core_stall, core_rvalid, dma_rvalid, addr_err});
    end
    n_cmp++;
    if ({ram_addr, ram_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus got addr %h wdata %h want 0", ram_addr, ram_wdata);
    end
    nreset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_core_read();
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd5;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, core_stall, ram_en, ram_we} !== 4'b1010) begin
      n_fail++;
      $display("FAIL core_read_issue got gnt/stall/en/we %b want 1010", {core_gnt, core_stall, ram_en, ram_we});
    end
    n_cmp++;
    if (ram_addr !== 10'd5) begin
      n_fail++;
      $display("FAIL core_read_addr got %0d want 5", ram_addr);
    end
    tick();
    idle_inputs();
    @(negedge clock);
    n_cmp++;
    if ({core_rvalid, dma_rvalid} !== 2'b10 || rdata !== 32'h1234) begin
      n_fail++;
      $display("FAIL core_read_data got rv %b rdata %h want 10 00001234", {core_rvalid, dma_rvalid}, rdata);
    end
    tick();
  endtask

  task automatic test_alternate();
    bit want_core;
    do_reset();
    core_req = 1'b1; core_we = 1'b1; core_addr = 10'($urandom_range(64, 127)); core_wdata = $urandom;
    dma_req  = 1'b1; dma_we  = 1'b1; dma_addr  = 10'($urandom_range(128, 191)); dma_wdata  = $urandom;
    dma_lock = 1'b0;
    for (int i = 0; i < 8; i++) begin
      want_core = (i % 2 == 0);
      @(negedge clock);
      n_cmp++;
      if ({core_gnt, dma_gnt, core_stall} !== {want_core, !want_core, !want_core}) begin
        n_fail++;
        $display("FAIL alternate cyc=%0d got gnt_c/gnt_d/stall %b want %b", i,
                 {core_gnt, dma_gnt, core_stall}, {want_core, !want_core, !want_core});
      end
      tick();
      if (want_core) begin core_addr = 10'($urandom_range(64, 127)); core_wdata = $urandom; end
      else           begin dma_addr  = 10'($urandom_range(128, 191)); dma_wdata  = $urandom; end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_burst();
    logic [DATAW-1:0] wd [20];
    int beat, crd, cyc;
    bit want_core;
    do_reset();
    for (int i = 0; i < 20; i++) wd[i] = $urandom;
    beat = 0; crd = 0; cyc = 0;
    while (beat < 20 && cyc < 40) begin
      core_req = 1'b1; core_we = 1'b0; core_addr = 10'(200 + crd);
      dma_req  = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
      dma_addr = 10'(beat); dma_wdata = wd[beat];
      // Tie goes to the core first, then 16 locked DMA beats, one core slot, rest of DMA.
      want_core = (cyc == 0) || (cyc == 17);
      @(negedge clock);
      n_cmp++;
      if ({core_gnt, dma_gnt, core_stall} !== {want_core, !want_core, !want_core}) begin
        n_fail++;
        $display("FAIL burst_gnt cyc=%0d got gnt_c/gnt_d/stall %b want %b", cyc,
                 {core_gnt, dma_gnt, core_stall}, {want_core, !want_core, !want_core});
      end
      if (m_rv_core) begin
        n_cmp++;
        if (core_rvalid !== 1'b1 || rdata !== m_rd) begin
          n_fail++;
          $display("FAIL burst_core_rdata cyc=%0d got rv %b rdata %h want 1 %h", cyc, core_rvalid, rdata, m_rd);
        end
      end
      tick();
      if (want_core) crd++;
      else beat++;
      cyc++;
    end
    n_cmp++;
    if (beat != 20) begin
      n_fail++;
      $display("FAIL burst_timeout got %0d beats want 20", beat);
    end
    idle_inputs();
    tick();
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (mem[i] !== wd[i]) begin
        n_fail++;
        $display("FAIL burst_mem[%0d] got %h want %h", i, mem[i], wd[i]);
      end
    end
  endtask

  task automatic test_lock_drop();
    do_reset();
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1; dma_addr = 10'd30; dma_wdata = 32'hA0A0_0001;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL lockdrop_beat1 got %b want 01", {core_gnt, dma_gnt});
    end
    tick();
    dma_addr = 10'd31; dma_wdata = 32'hA0A0_0002;
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd40;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt, core_stall} !== 3'b011) begin
      n_fail++; $display("FAIL lockdrop_beat2 got %b want 011", {core_gnt, dma_gnt, core_stall});
    end
    tick();
    dma_addr = 10'd32; dma_wdata = 32'hA0A0_0003; dma_lock = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt, core_stall} !== 3'b011) begin
      n_fail++; $display("FAIL lockdrop_beat3 got %b want 011", {core_gnt, dma_gnt, core_stall});
    end
    tick();
    dma_addr = 10'd33; dma_wdata = 32'hA0A0_0004; dma_lock = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt, core_stall} !== 3'b100) begin
      n_fail++; $display("FAIL lockdrop_core got %b want 100", {core_gnt, dma_gnt, core_stall});
    end
    tick();
    core_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (dma_gnt !== 1'b1) begin
      n_fail++; $display("FAIL lockdrop_resume got %b want 1", dma_gnt);
    end
    tick();
    idle_inputs();
    tick();
    n_cmp++;
    if (mem[32] !== 32'hA0A0_0003) begin
      n_fail++; $display("FAIL lockdrop_mem32 got %h want a0a00003", mem[32]);
    end
  endtask

  task automatic test_oor();
    do_reset();
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'(RAMDEPTH);
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, core_stall, ram_en, addr_err} !== 4'b1000) begin
      n_fail++; $display("FAIL oor_issue got gnt/stall/en/err %b want 1000", {core_gnt, core_stall, ram_en, addr_err});
    end
    tick();
    core_we = 1'b1; core_addr = 10'd3; core_wdata = 32'hCAFE_F00D;
    @(negedge clock);
    n_cmp++;
    if ({core_rvalid, addr_err} !== 2'b11 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL oor_return got rv/err %b rdata %h want 11 00000000", {core_rvalid, addr_err}, rdata);
    end
    n_cmp++;
    if ({core_gnt, ram_en, ram_we} !== 3'b111) begin
      n_fail++; $display("FAIL oor_valid_write got %b want 111", {core_gnt, ram_en, ram_we});
    end
    tick();
    core_we = 1'b0;
    tick();
    idle_inputs();
    @(negedge clock);
    n_cmp++;
    if ({core_rvalid, addr_err} !== 2'b11 || rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL oor_sticky got rv/err %b rdata %h want 11 cafef00d", {core_rvalid, addr_err}, rdata);
    end
    tick();
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 10'd1000; dma_wdata = 32'h1111_2222;
    @(negedge clock);
    n_cmp++;
    if ({dma_gnt, ram_en, ram_we, addr_err} !== 4'b1001) begin
      n_fail++; $display("FAIL oor_dma_write got gnt/en/we/err %b want 1001", {dma_gnt, ram_en, ram_we, addr_err});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_burst();
    do_reset();
    dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 10'd7;
    tick();
    dma_addr = 10'd8;
    tick();
    @(negedge clock);
    n_cmp++;
    if (dma_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL rstburst_pending got %b want 1", dma_rvalid);
    end
    idle_inputs();
    nreset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({dma_rvalid, core_rvalid, dma_gnt, core_gnt} !== 4'b0000) begin
      n_fail++; $display("FAIL rstburst_drop got %b want 0000", {dma_rvalid, core_rvalid, dma_gnt, core_gnt});
    end
    #8;
    nreset = 1'b1;
    @(posedge clock);
    #1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 10'd9;
    dma_req  = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 10'd10;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL rstburst_first got %b want 10", {core_gnt, dma_gnt});
    end
    tick();
    core_req = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({core_gnt, dma_gnt} !== 2'b01) begin
      n_fail++; $display("FAIL rstburst_second got %b want 01", {core_gnt, dma_gnt});
    end
    tick();
    idle_inputs();
    tick();
  endtask

  function automatic logic [ADDRW-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return ADDRW'($urandom_range(RAMDEPTH, NWORDS - 1));
    return ADDRW'($urandom_range(0, 63));
  endfunction

  task automatic test_random();
    bit last_cg, last_dg;
    do_reset();
    last_cg = 1'b0; last_dg = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!core_req || last_cg) begin
        core_req   = ($urandom_range(0, 99) < 60);
        core_we    = $urandom_range(0, 1) == 1;
        core_addr  = rand_addr();
        core_wdata = $urandom;
      end
      if (!dma_req || last_dg) begin
        dma_req   = ($urandom_range(0, 99) < 65);
        dma_lock  = ($urandom_range(0, 3) != 0);
        dma_we    = $urandom_range(0, 1) == 1;
        dma_addr  = rand_addr();
        dma_wdata = $urandom;
      end
      @(negedge clock);
      model_eval();
      n_cmp++;
      if ({core_gnt, dma_gnt, core_stall, ram_en, ram_we} !== {e_cg, e_dg, e_stall, e_en, e_we}) begin
        n_fail++;
        $display("FAIL rand_ctrl cyc=%0d got %b want %b", cyc,
                 {core_gnt, dma_gnt, core_stall, ram_en, ram_we}, {e_cg, e_dg, e_stall, e_en, e_we});
      end
      if (e_en) begin
        n_cmp++;
        if (ram_addr !== e_addr) begin
          n_fail++; $display("FAIL rand_addr cyc=%0d got %h want %h", cyc, ram_addr, e_addr);
        end
      end
      if (e_we) begin
        n_cmp++;
        if (ram_wdata !== e_wdata) begin
          n_fail++; $display("FAIL rand_wdata cyc=%0d got %h want %h", cyc, ram_wdata, e_wdata);
        end
      end
      n_cmp++;
      if ({core_rvalid, dma_rvalid, addr_err} !== {m_rv_core, m_rv_dma, m_err}) begin
        n_fail++;
        $display("FAIL rand_ret cyc=%0d got %b want %b", cyc,
                 {core_rvalid, dma_rvalid, addr_err}, {m_rv_core, m_rv_dma, m_err});
      end
      if (m_rv_core || m_rv_dma) begin
        n_cmp++;
        if (rdata !== m_rd) begin
          n_fail++; $display("FAIL rand_rdata cyc=%0d got %h want %h", cyc, rdata, m_rd);
        end
      end
      last_cg = e_cg;
      last_dg = e_dg;
      tick();
    end
    idle_inputs();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);
    model_reset();
    test_reset();
    test_core_read();
    test_alternate();
    test_burst();
    test_lock_drop();
    test_oor();
    test_reset_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
